alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Shares the single combinational 32-bit ALU between two requesters: req0 (execute stage) and req1 (address/aux unit).
- Arbitrates round-robin and sequences each operation through a 3-state FSM.
- Evaluates ARM-style condition codes against an internal NZCV flag register, updates the flags, and returns a registered result via a valid/ready response.

Parameters:
- W, 32, operand/result width. Fixed to the ALU width; other values unsupported.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request N valid (N=0,1)
- reqN_ready  out  1  request N accepted this cycle when valid&ready
- reqN_a, reqN_b  in  32  operands
- reqN_op  in  4  ALU opcode (AND=0 … MVN=F)
- reqN_s  in  1  set-flags request
- reqN_cond  in  4  condition code
- alu_a, alu_b  out  32  to ALU
- alu_opcode  out  4  to ALU
- alu_carry  out  1  to ALU carry-in
- alu_c  in  32  ALU result
- alu_flags  in  4  ALU {N,Z,C,V}, bit3=N
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index
- rsp_result  out  32  latched ALU result
- rsp_exec  out  1  condition passed
- rsp_wb  out  1  result destined for register write
- flags  out  4  current NZCV, bit3=N
- flag_load  in  1  load flags from flag_din (MSR)
- flag_din  in  4  new NZCV

Behaviour:
- Reset: FSM=IDLE, flags=0, rr_ptr=0, all outputs 0, rsp_* 0, reqN_ready 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one requester is valid, it wins. If both are valid, rr_ptr wins.
  - reqN_ready=1 only for the granted requester; 0 in every other state.
  - On handshake: capture a, b, op, s, cond and id into registers; rr_ptr <= ~id; go to EXEC.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_opcode are driven from the captured registers; alu_carry=flags[C]. Outside EXEC these outputs hold their last values.
  - pass = cond evaluated on the current flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
  - Latch: rsp_result<=alu_c, rsp_exec<=pass, rsp_id<=id.
  - rsp_wb <= pass & (op not in 8..B).
  - Flag update occurs iff pass & (s | op in 8..B). Compares always set flags.
  - Arithmetic ops (2-7, A, B): NZCV <= alu_flags.
  - Logical ops (0, 1, 8, 9, C-F): N, Z from alu_flags; C and V preserved.
  - Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields held stable.
  - When rsp_ready=1: clear rsp_valid and go to IDLE.
- Latency and throughput:
  - Handshake at edge T gives rsp_valid at edge T+2.
  - Minimum 3 cycles per operation with rsp_ready tied high.
- Failed condition: result is still latched; rsp_exec=0, rsp_wb=0, flags unchanged.
- flag_load:
  - Applies in any state, 1-cycle effect.
  - Same cycle as an EXEC flag update: the EXEC update wins and the load is discarded.
  - In EXEC with no flag update: the load applies, and the condition uses the pre-load flags.
- Reset mid-operation: immediate return to IDLE, in-flight op discarded, flags=0.
- Requester dropping valid before grant: no effect.

Test Plan:
- Single request: req0 ADD a=0x7FFFFFFF, b=1, s=1, cond=E.
  - Response 2 cycles after accept: result=0x80000000, exec=1, wb=1, flags=N1 Z0 C0 V1 (0x9).
- Contention: both valid continuously, rsp_ready=1, after reset.
  - Grants alternate 0,1,0,1; one response every 3 cycles; rsp_id matches the grant.
- Conditional skip: flags=0x4 (Z), req1 SUB cond=1 (NE) a=5 b=3.
  - rsp_exec=0, wb=0, result=2, flags stay 0x4.
- Compare and logical flags:
  - CMP a=3 b=3 with s=0 gives flags=0x6 (Z, C), wb=0.
  - Then AND a=0 b=0 s=1 with flags C=1 → flags=0x6; C preserved, V preserved.
- Backpressure: rsp_ready=0 for 5 cycles.
  - rsp_valid and fields stable throughout; both reqN_ready=0; pending request is accepted the cycle after rsp_ready=1 returns to IDLE.
- Collision and reset:
  - flag_load=1 flag_din=0xF during an EXEC of ADDS 1+1: flags=0x0.
  - Assert reset_n=0 during RESP: rsp_valid drops immediately, flags=0.

Source files
------------

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
//   Time-shares one external combinational 32-bit ALU between two requesters
//   (req0 = execute stage, req1 = address/aux unit). Requests are granted
//   round-robin in IDLE, evaluated for one cycle in EXEC, and returned through
//   a registered valid/ready response in RESP. ARM-style condition codes are
//   evaluated against an internal NZCV register, which the operation may
//   update.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   reqN_valid/ready          request handshake, N = 0,1
//   reqN_a/b/op/s/cond        operands, opcode, set-flags, condition code
//   alu_a/b/opcode/carry      operands and carry-in to the external ALU
//   alu_c, alu_flags          ALU result and {N,Z,C,V}
//   rsp_valid/ready           response handshake
//   rsp_id/result/exec/wb     requester, latched result, cond passed, write-back
//   flags                     current NZCV (bit3 = N)
//   flag_load, flag_din       direct NZCV load (MSR)
// -----------------------------------------------------------------------------
module alu_sched #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req0_s,
    input  logic [3:0]   req0_cond,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_op,
    input  logic         req1_s,
    input  logic [3:0]   req1_cond,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    output logic         alu_carry,
    input  logic [W-1:0] alu_c,
    input  logic [3:0]   alu_flags,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_exec,
    output logic         rsp_wb,

    output logic [3:0]   flags,
    input  logic         flag_load,
    input  logic [3:0]   flag_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       rr_ptr;
    logic       id_q;
    logic       s_q;
    logic [3:0] cond_q;
    logic       carry_q;

    logic       gnt_valid;
    logic       gnt_id;
    logic       pass;
    logic       is_test;
    logic       is_arith;

    // Condition pairs share a base test; odd codes are the inverse of the
    // even code below them (EQ/NE, CS/CC, ..., AL/NV).
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        {n, z, c, v} = nzcv;
        base = 1'b0;
        unique case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            3'd7: base = 1'b1;
        endcase
        return cond[0] ? ~base : base;
    endfunction

    // Grant is combinational so a lone requester is accepted in the same
    // cycle it shows up in IDLE.
    // NOTE: every combinationally assigned signal gets a default at the top of
    // the block; otherwise a missed branch infers a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = rr_ptr;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_valid & ~gnt_id;
    assign req1_ready = gnt_valid &  gnt_id;

    // TST/TEQ/CMP/CMN (8..B) never write back and always set flags.
    assign is_test  = (alu_opcode[3:2] == 2'b10);
    // SUB..RSC (2..7) and CMP/CMN (A,B) produce meaningful C and V.
    assign is_arith = (~alu_opcode[3] & (alu_opcode[2:1] != 2'b00)) |
                      (alu_opcode[3:1] == 3'b101);

    // Evaluated on the flags as they stand in EXEC, i.e. before any load that
    // lands at the end of that cycle.
    assign pass = cond_pass(cond_q, flags);

    // Carry-in tracks the live C flag during EXEC and holds afterwards.
    assign alu_carry = (state == EXEC) ? flags[1] : carry_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order; later
    // assignments in the block take priority over earlier ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            id_q       <= 1'b0;
            s_q        <= 1'b0;
            cond_q     <= 4'd0;
            carry_q    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_exec   <= 1'b0;
            rsp_wb     <= 1'b0;
            flags      <= 4'd0;
        end else begin
            // Direct load applies in any state; an EXEC flag update below
            // overrides it in the same cycle.
            if (flag_load) begin
                flags <= flag_din;
            end

            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        alu_a      <= gnt_id ? req1_a    : req0_a;
                        alu_b      <= gnt_id ? req1_b    : req0_b;
                        alu_opcode <= gnt_id ? req1_op   : req0_op;
                        s_q        <= gnt_id ? req1_s    : req0_s;
                        cond_q     <= gnt_id ? req1_cond : req0_cond;
                        id_q       <= gnt_id;
                        rr_ptr     <= ~gnt_id;
                        state      <= EXEC;
                    end
                end

                EXEC: begin
                    rsp_result <= alu_c;
                    rsp_exec   <= pass;
                    rsp_id     <= id_q;
                    rsp_wb     <= pass & ~is_test;
                    carry_q    <= flags[1];
                    if (pass && (s_q || is_test)) begin
                        // Logical ops leave C and V untouched.
                        flags <= is_arith ? alu_flags : {alu_flags[3:2], flags[1:0]};
                    end
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched
//   Self-checking bench for alu_sched. Provides a behavioural ARM-style ALU on
//   the alu_* port, predicts each response when its request is accepted and
//   compares it when the response is consumed, plus directed checks.
// -----------------------------------------------------------------------------
module tb_alu_sched;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   req0_op = 4'd0, req1_op = 4'd0;
    logic         req0_s = 1'b0, req1_s = 1'b0;
    logic [3:0]   req0_cond = 4'hE, req1_cond = 4'hE;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [3:0]   alu_opcode, alu_flags;
    logic         alu_carry;
    logic         rsp_valid, rsp_id, rsp_exec, rsp_wb;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic [3:0]   flags;
    logic         flag_load = 1'b0;
    logic [3:0]   flag_din = 4'd0;

    always #5 clk = ~clk;

    alu_sched #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_s(req0_s), .req0_cond(req0_cond),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_s(req1_s), .req1_cond(req1_cond),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_carry(alu_carry),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_exec(rsp_exec), .rsp_wb(rsp_wb),
        .flags(flags), .flag_load(flag_load), .flag_din(flag_din)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference ALU ----------------
    // Returns {N,Z,C,V, result}. Logical ops report C = ~cin, V = 1 so that a
    // scheduler wrongly copying C/V on logical ops is visible.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic cin);
        logic [32:0] sum;
        logic [31:0] x, y, r;
        logic        ci, arith, c, v;
        x = a; y = b; ci = 1'b0; arith = 1'b1; r = '0;
        case (op)
            4'h0: begin r = a & b;  arith = 1'b0; end
            4'h1: begin r = a ^ b;  arith = 1'b0; end
            4'h2: begin x = a; y = ~b; ci = 1'b1; end
            4'h3: begin x = b; y = ~a; ci = 1'b1; end
            4'h4: begin x = a; y = b;  ci = 1'b0; end
            4'h5: begin x = a; y = b;  ci = cin;  end
            4'h6: begin x = a; y = ~b; ci = cin;  end
            4'h7: begin x = b; y = ~a; ci = cin;  end
            4'h8: begin r = a & b;  arith = 1'b0; end
            4'h9: begin r = a ^ b;  arith = 1'b0; end
            4'hA: begin x = a; y = ~b; ci = 1'b1; end
            4'hB: begin x = a; y = b;  ci = 1'b0; end
            4'hC: begin r = a | b;  arith = 1'b0; end
            4'hD: begin r = b;      arith = 1'b0; end
            4'hE: begin r = a & ~b; arith = 1'b0; end
            default: begin r = ~b;  arith = 1'b0; end
        endcase
        if (arith) begin
            sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            r   = sum[31:0];
            c   = sum[32];
            v   = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            c = ~cin;
            v = 1'b1;
        end
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_c} = alu_fn(alu_a, alu_b, alu_opcode, alu_carry);

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        exec;
        logic        wb;
        logic [3:0]  flg;
    } exp_t;

    exp_t sbq[$];
    logic gnt_log[$];
    int   gnt_cyc_log[$];

    logic [3:0]  m_flags  = 4'd0;
    logic        m_rr     = 1'b0;
    logic        exec_load = 1'b0;
    logic [3:0]  exec_din  = 4'd0;

    int          cyc = 0;
    int          grant_cyc = 0;
    logic        rsp_valid_d = 1'b0;
    logic [31:0] last_result;
    logic        last_exec, last_wb;
    logic [3:0]  last_flags;

    task automatic model_push(input logic id, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic s, input logic [3:0] cc);
        logic [35:0] o;
        logic [3:0]  nf;
        bit          p, tst, ar;
        exp_t        e;
        o   = alu_fn(a, b, op, m_flags[1]);
        p   = cond_ok(cc, m_flags);
        tst = (op >= 4'h8) && (op <= 4'hB);
        ar  = ((op >= 4'h2) && (op <= 4'h7)) || (op == 4'hA) || (op == 4'hB);
        nf  = m_flags;
        if (p && (s || tst)) nf = ar ? o[35:32] : {o[35:34], m_flags[1:0]};
        else if (exec_load) nf = exec_din;
        e.id = id; e.result = o[31:0]; e.exec = p; e.wb = p && !tst; e.flg = nf;
        sbq.push_back(e);
        m_flags = nf;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            rsp_valid_d = 1'b0;
        end else begin
            cyc++;
            if (rsp_valid && !rsp_valid_d) check("latency", cyc - grant_cyc, 2);
            rsp_valid_d = rsp_valid;
            if (req0_ready || req1_ready) begin
                check("ready_onehot", {31'd0, req0_ready && req1_ready}, 0);
                if (req0_valid && req1_valid) check("rr_grant", {31'd0, req1_ready}, {31'd0, m_rr});
                m_rr = ~req1_ready;
                gnt_log.push_back(req1_ready);
                gnt_cyc_log.push_back(cyc);
                grant_cyc = cyc;
                if (req1_ready) model_push(1'b1, req1_a, req1_b, req1_op, req1_s, req1_cond);
                else            model_push(1'b0, req0_a, req0_b, req0_op, req0_s, req0_cond);
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_id",     {31'd0, rsp_id},   {31'd0, e.id});
                    check("rsp_result", rsp_result,        e.result);
                    check("rsp_exec",   {31'd0, rsp_exec}, {31'd0, e.exec});
                    check("rsp_wb",     {31'd0, rsp_wb},   {31'd0, e.wb});
                    check("rsp_flags",  {28'd0, flags},    {28'd0, e.flg});
                    last_result = rsp_result;
                    last_exec   = rsp_exec;
                    last_wb     = rsp_wb;
                    last_flags  = flags;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #12;
        sbq.delete();
        m_flags = 4'd0;
        m_rr    = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic s, input logic [3:0] cc);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_s = s; req1_cond = cc; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_s = s; req0_cond = cc; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) check("grant_timeout", 0, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (exec_load) begin
            flag_load = 1'b1; flag_din = exec_din;
            @(posedge clk); #1;
            flag_load = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = (sbq.size() == 0);
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic load_flags(input logic [3:0] d);
        @(posedge clk); #1;
        flag_load = 1'b1; flag_din = d;
        @(posedge clk); #1;
        flag_load = 1'b0;
        m_flags = d;
        check("flag_load", {28'd0, flags}, {28'd0, d});
    endtask

    task automatic wait_rsp_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        // Reset state
        reset_n = 1'b0;
        #12;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_flags",     {28'd0, flags}, 0);
        check("rst_ready",     {30'd0, req0_ready, req1_ready}, 0);
        check("rst_result",    rsp_result, 0);
        check("rst_alu_a",     alu_a, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single ADDS overflowing into the sign bit
        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 4'h4, 1'b1, 4'hE);
        drain();
        check("single_result", last_result, 32'h8000_0000);
        check("single_exec",   {31'd0, last_exec}, 1);
        check("single_wb",     {31'd0, last_wb}, 1);
        check("single_flags",  {28'd0, flags}, 32'h9);

        // Contention: both requesters valid continuously from reset
        do_reset();
        gnt_log.delete();
        gnt_cyc_log.delete();
        @(posedge clk); #1;
        req0_a = 32'd1;  req0_b = 32'd2;  req0_op = 4'h4; req0_s = 1'b0; req0_cond = 4'hE;
        req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 4'h1; req1_s = 1'b1; req1_cond = 4'hE;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (13) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        if (gnt_log.size() < 4) begin
            check("contention_count", gnt_log.size(), 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("contention_order", {31'd0, gnt_log[i]}, i % 2);
                if (i > 0) check("contention_spacing", gnt_cyc_log[i] - gnt_cyc_log[i-1], 3);
            end
        end

        // Conditional skip: NE with Z set
        load_flags(4'h4);
        issue(1'b1, 32'd5, 32'd3, 4'h2, 1'b1, 4'h1);
        drain();
        check("skip_exec",   {31'd0, last_exec}, 0);
        check("skip_wb",     {31'd0, last_wb}, 0);
        check("skip_result", last_result, 32'd2);
        check("skip_flags",  {28'd0, flags}, 32'h4);

        // CMP sets flags without S; AND then keeps C/V
        issue(1'b0, 32'd3, 32'd3, 4'hA, 1'b0, 4'hE);
        drain();
        check("cmp_flags", {28'd0, flags}, 32'h6);
        check("cmp_wb",    {31'd0, last_wb}, 0);
        issue(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 4'hE);
        drain();
        check("and_flags", {28'd0, flags}, 32'h6);

        // Backpressure with a request pending on req1
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 32'd10, 32'd20, 4'h4, 1'b0, 4'hE);
        req1_a = 32'd7; req1_b = 32'd1; req1_op = 4'h2; req1_s = 1'b0; req1_cond = 4'hE;
        req1_valid = 1'b1;
        wait_rsp_valid();
        repeat (5) begin
            @(negedge clk);
            check("bp_valid",  {31'd0, rsp_valid}, 1);
            check("bp_result", rsp_result, 32'd30);
            check("bp_ready",  {30'd0, req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_grant", {31'd0, req1_ready}, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();
        check("bp_second_result", last_result, 32'd6);

        // flag_load colliding with an EXEC flag update: update wins
        exec_load = 1'b1; exec_din = 4'hF;
        issue(1'b0, 32'd1, 32'd1, 4'h4, 1'b1, 4'hE);
        exec_load = 1'b0;
        drain();
        check("collide_flags", {28'd0, flags}, 32'h0);

        // flag_load during EXEC with no update: load applies, cond uses old flags
        load_flags(4'h4);
        exec_load = 1'b1; exec_din = 4'h0;
        issue(1'b1, 32'd5, 32'd3, 4'h2, 1'b1, 4'h1);
        exec_load = 1'b0;
        drain();
        check("load_exec_pass", {31'd0, last_exec}, 0);
        check("load_exec_flags", {28'd0, flags}, 32'h0);

        // Reset during RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 4'h4, 1'b1, 4'hE);
        wait_rsp_valid();
        check("pre_reset_flags", {28'd0, flags}, 32'h9);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 0);
        check("reset_flags",     {28'd0, flags}, 0);
        sbq.delete();
        m_flags = 4'd0;
        m_rr    = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b1, 32'd2, 32'd3, 4'h4, 1'b1, 4'hE);
        drain();
        check("post_reset_result", last_result, 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
